// File: rtl/pattern_buffer_if.sv
// Field, load and serial-stream signals between the processor/host (master) and the
// pattern buffer bank (slave).
interface pattern_buffer_if #(
  parameter int unsigned BUFP_WIDTH   = 3,
  parameter int unsigned FIELDP_WIDTH = 5,
  parameter int unsigned BUFFER_WIDTH = 8
);
  localparam int unsigned BUF_BITS = 2 ** FIELDP_WIDTH;

  logic [BUFP_WIDTH-1:0]   bufp;
  logic [FIELDP_WIDTH-1:0] fieldp;
  logic [FIELDP_WIDTH-1:0] fieldwp;
  logic [BUFFER_WIDTH-1:0] field_out;
  logic                    field_we;
  logic [BUFFER_WIDTH-1:0] field_in;

  logic                    ld_en;
  logic [BUFP_WIDTH-1:0]   ld_buf;
  logic [BUF_BITS-1:0]     ld_data;

  logic                    tx_start;
  logic [BUFP_WIDTH-1:0]   tx_buf;
  logic                    tx_valid;
  logic                    tx_data;
  logic                    tx_ready;
  logic                    tx_busy;
  logic                    tx_done;

  modport master (
    output bufp, fieldp, fieldwp, field_out, field_we,
    output ld_en, ld_buf, ld_data,
    output tx_start, tx_buf, tx_ready,
    input  field_in, tx_valid, tx_data, tx_busy, tx_done
  );

  modport slave (
    input  bufp, fieldp, fieldwp, field_out, field_we,
    input  ld_en, ld_buf, ld_data,
    input  tx_start, tx_buf, tx_ready,
    output field_in, tx_valid, tx_data, tx_busy, tx_done
  );
endinterface

// File: rtl/pattern_buffer.sv
// Bank of circular bit buffers: wrapping 8-bit field read/write windows, whole-buffer loads
// and an LSB-first serial stream of a snapshot over valid/ready.
module pattern_buffer #(
  parameter int unsigned BUFP_WIDTH   = 3,
  parameter int unsigned FIELDP_WIDTH = 5,
  parameter int unsigned BUFFER_WIDTH = 8
) (
  input logic              clk,
  input logic              reset,
  pattern_buffer_if.slave  bus
);
  localparam int unsigned NUM_BUF  = 2 ** BUFP_WIDTH;
  localparam int unsigned BUF_BITS = 2 ** FIELDP_WIDTH;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StDone  = 2'd2;

  logic [BUF_BITS-1:0]     mem_q [NUM_BUF];
  logic [BUF_BITS-1:0]     mem_d [NUM_BUF];
  logic [BUF_BITS-1:0]     rd_word;
  logic [FIELDP_WIDTH-1:0] rd_idx;
  logic [FIELDP_WIDTH-1:0] wr_idx;
  logic [BUFFER_WIDTH-1:0] rd_field;

  logic [1:0]              state_q, state_d;
  logic [BUF_BITS-1:0]     shift_q, shift_d;
  logic [FIELDP_WIDTH-1:0] cnt_q, cnt_d;

  // Field read: offset arithmetic in FIELDP_WIDTH bits gives the wrap for free.
  assign rd_word = mem_q[bus.bufp];

  always_comb begin
    rd_field = '0;
    rd_idx   = '0;
    for (int i = 0; i < BUFFER_WIDTH; i++) begin
      rd_idx      = bus.fieldp + FIELDP_WIDTH'(i);
      rd_field[i] = rd_word[rd_idx];
    end
  end

  assign bus.field_in = rd_field;

  // Load first, then the field window on top, so a same-cycle pair merges.
  always_comb begin
    mem_d  = mem_q;
    wr_idx = '0;
    if (bus.ld_en) begin
      mem_d[bus.ld_buf] = bus.ld_data;
    end
    if (bus.field_we) begin
      for (int i = 0; i < BUFFER_WIDTH; i++) begin
        wr_idx                   = bus.fieldwp + FIELDP_WIDTH'(i);
        mem_d[bus.bufp][wr_idx] = bus.field_out[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.tx_start) begin
          shift_d = mem_q[bus.tx_buf];
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        if (bus.tx_ready) begin
          shift_d = {1'b0, shift_q[BUF_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == '1) begin
            state_d = StDone;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.tx_valid = (state_q == StShift);
  assign bus.tx_data  = (state_q == StShift) & shift_q[0];
  assign bus.tx_busy  = (state_q == StShift) || (state_q == StDone);
  assign bus.tx_done  = (state_q == StDone);

endmodule

// File: tb/tb_pattern_buffer.sv
// Directed bench for pattern_buffer; a forked monitor scores the serial stream against a queue.
module tb_pattern_buffer;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pattern_buffer_if #(.BUFP_WIDTH(3), .FIELDP_WIDTH(5), .BUFFER_WIDTH(8)) bus ();

  pattern_buffer #(.BUFP_WIDTH(3), .FIELDP_WIDTH(5), .BUFFER_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  int   acc_cnt  = 0;
  logic hold_pend = 1'b0;
  logic held_bit  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input logic [31:0] word);
    for (int i = 0; i < 32; i++) exp_q.push_back(word[i]);
  endtask

  task automatic read_field(input string name, input logic [2:0] b, input logic [4:0] p,
                            input logic [7:0] exp);
    bus.bufp   = b;
    bus.fieldp = p;
    #1;
    check(name, 32'(bus.field_in), 32'(exp));
  endtask

  task automatic monitor;
    logic b;
    forever begin
      @(negedge clk);
      if (hold_pend && bus.tx_valid) check("tx_hold", 32'(bus.tx_data), 32'(held_bit));
      hold_pend = bus.tx_valid && !bus.tx_ready;
      held_bit  = bus.tx_data;
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL tx_bit: got unexpected bit %0b, expected none", bus.tx_data);
        end else begin
          b = exp_q.pop_front();
          if (bus.tx_data !== b) begin
            failures++;
            $display("FAIL tx_bit: got %0b, expected %0b", bus.tx_data, b);
          end
        end
        acc_cnt++;
      end
      if (bus.tx_done === 1'b1) begin
        check("tx_done_count", 32'(acc_cnt), 32'd32);
        check("tx_done_queue", 32'(exp_q.size()), 32'd0);
        acc_cnt = 0;
      end
      if (reset) begin
        exp_q.delete();
        acc_cnt   = 0;
        hold_pend = 1'b0;
      end
    end
  endtask

  initial begin
    int   done_k;
    logic seen_done;

    reset         = 1'b1;
    bus.bufp      = '0;
    bus.fieldp    = '0;
    bus.fieldwp   = '0;
    bus.field_out = '0;
    bus.field_we  = 1'b0;
    bus.ld_en     = 1'b0;
    bus.ld_buf    = '0;
    bus.ld_data   = '0;
    bus.tx_start  = 1'b0;
    bus.tx_buf    = '0;
    bus.tx_ready  = 1'b0;

    fork
      monitor();
    join_none

    tick();
    tick();
    reset = 1'b0;

    // Reset state.
    for (int b = 0; b < 8; b++) begin
      read_field("reset_rd_p0", 3'(b), 5'd0, 8'h00);
      read_field("reset_rd_p24", 3'(b), 5'd24, 8'h00);
    end
    check("reset_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("reset_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("reset_tx_done", 32'(bus.tx_done), 32'd0);

    // Load and wrap-around read.
    bus.ld_en = 1'b1; bus.ld_buf = 3'd2; bus.ld_data = 32'h8000_0001;
    tick();
    bus.ld_en = 1'b0;
    read_field("wrap_rd", 3'd2, 5'd28, 8'h18);

    // Wrapping field write; same-cycle read still sees old data.
    bus.field_we = 1'b1; bus.fieldwp = 5'd30; bus.field_out = 8'hA5;
    read_field("wr_same_cycle", 3'd5, 5'd30, 8'h00);
    tick();
    bus.field_we = 1'b0;
    read_field("wr_rd_p30", 3'd5, 5'd30, 8'hA5);
    read_field("wr_rd_p0", 3'd5, 5'd0, 8'h29);
    read_field("wr_rd_p6", 3'd5, 5'd6, 8'h00);
    read_field("wr_rd_p14", 3'd5, 5'd14, 8'h00);
    read_field("wr_rd_p22", 3'd5, 5'd22, 8'h00);

    // Full-rate stream of buf 1 with a field write to it mid-transfer.
    bus.ld_en = 1'b1; bus.ld_buf = 3'd1; bus.ld_data = 32'h0000_000F;
    tick();
    bus.ld_en = 1'b0;
    bus.tx_start = 1'b1; bus.tx_buf = 3'd1; bus.tx_ready = 1'b1;
    push_stream(32'h0000_000F);
    tick();
    bus.tx_start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) begin
        bus.field_we = 1'b1; bus.bufp = 3'd1; bus.fieldwp = 5'd0; bus.field_out = 8'hFF;
      end
      if (k == 6) bus.field_we = 1'b0;
      @(negedge clk);
      if (k == 1) begin
        check("stream_busy_first", 32'(bus.tx_busy), 32'd1);
        check("stream_valid_first", 32'(bus.tx_valid), 32'd1);
      end
      if (bus.tx_done && done_k == 0) done_k = k;
      tick();
      if (done_k != 0) break;
    end
    check("stream_done_cycle", 32'(done_k), 32'd33);
    check("stream_idle_busy", 32'(bus.tx_busy), 32'd0);
    check("stream_idle_valid", 32'(bus.tx_valid), 32'd0);
    read_field("stream_wr_applied", 3'd1, 5'd0, 8'hFF);
    read_field("stream_wr_p4", 3'd1, 5'd4, 8'h0F);

    // Backpressure: ready toggles, second start while busy must be ignored.
    bus.tx_start = 1'b1; bus.tx_buf = 3'd2; bus.tx_ready = 1'b0;
    push_stream(32'h8000_0001);
    tick();
    bus.tx_start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 200; k++) begin
      bus.tx_ready = (k % 2 == 1);
      if (k == 3) begin
        bus.tx_start = 1'b1; bus.tx_buf = 3'd1;
      end
      if (k == 4) bus.tx_start = 1'b0;
      @(negedge clk);
      if (bus.tx_done && done_k == 0) done_k = k;
      tick();
      if (done_k != 0) break;
    end
    check("bp_done_cycle", 32'(done_k), 32'd64);
    bus.tx_ready = 1'b1;
    check("bp_after_valid", 32'(bus.tx_valid), 32'd0);
    tick();
    check("bp_no_restart", 32'(bus.tx_busy), 32'd0);

    // Reset at bit 10 overrides same-cycle load, write and start.
    bus.tx_start = 1'b1; bus.tx_buf = 3'd2;
    push_stream(32'h8000_0001);
    tick();
    bus.tx_start = 1'b0;
    repeat (10) tick();
    reset = 1'b1;
    bus.ld_en = 1'b1; bus.ld_buf = 3'd0; bus.ld_data = 32'hFFFF_FFFF;
    bus.field_we = 1'b1; bus.bufp = 3'd4; bus.fieldwp = 5'd0; bus.field_out = 8'hFF;
    bus.tx_start = 1'b1; bus.tx_buf = 3'd1;
    tick();
    reset = 1'b0;
    bus.ld_en = 1'b0; bus.field_we = 1'b0; bus.tx_start = 1'b0;
    check("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
    check("rst_tx_busy", 32'(bus.tx_busy), 32'd0);
    check("rst_tx_data", 32'(bus.tx_data), 32'd0);
    check("rst_tx_done", 32'(bus.tx_done), 32'd0);
    for (int b = 0; b < 8; b++) read_field("rst_rd_p0", 3'(b), 5'd0, 8'h00);
    read_field("rst_rd_buf2_p28", 3'd2, 5'd28, 8'h00);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.tx_done !== 1'b0) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
